// File: rtl/cp_pkg.sv
// Shared definitions for the column-parity sequencer: state encoding and
// the default sizing constants used by the top-level parameters.
package cp_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PREP,
        S_LOAD_INIT,
        S_PAR1,
        S_PAR2,
        S_INIT,
        S_LOAD,
        S_CALC,
        S_PROC,
        S_NEXT,
        S_STAB,
        S_MAT_END,
        S_HOLD
    } state_t;

    localparam int DEF_SLICES   = 64;
    localparam int DEF_ROWS     = 5;
    localparam int DEF_EXT_DONE = 0;
    localparam int DEF_MAXMAT   = 64;

endpackage

// File: rtl/cp_param_counter.sv
// Generic up-counter with clear, load and a terminal-count flag. Clear has
// priority over load, load over increment; wrapping is left to the user,
// who can load zero when the terminal flag is seen.
module cp_param_counter #(
    parameter int WIDTH = 4,
    parameter int TERM  = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    assign at_term = (count == WIDTH'(TERM));

    // Count register: clear, then load, then increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/col_parity_sequencer.sv
// Control sequencer for a column-parity datapath: walks each matrix of a
// job through load/parity/processing phases, hands completed matrices
// downstream with a held handshake and signals the end of the job.
module col_parity_sequencer
    import cp_pkg::*;
#(
    parameter int SLICES   = DEF_SLICES,
    parameter int ROWS     = DEF_ROWS,
    parameter int EXT_DONE = DEF_EXT_DONE,
    parameter int MAXMAT   = DEF_MAXMAT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [$clog2(MAXMAT+1)-1:0]   num_mat,
    input  logic                          done,
    input  logic                          abort,
    input  logic                          out_ack,
    output logic                          ready,
    output logic                          busy,
    output logic                          mat_done,
    output logic                          job_done,
    output logic                          ld1,
    output logic                          ld2,
    output logic                          ld3,
    output logic                          shift,
    output logic                          id_rst,
    output logic                          inc_i,
    output logic [$clog2(SLICES)-1:0]     slice_idx,
    output logic [$clog2(MAXMAT)-1:0]     mat_idx
);

    localparam int NW = $clog2(MAXMAT + 1);
    localparam int SW = $clog2(SLICES);
    localparam int MW = $clog2(MAXMAT);
    localparam int RW = $clog2(ROWS + 1);

    state_t          state;
    state_t          next_state;
    logic [NW-1:0]   num_mat_q;
    logic [RW-1:0]   row_cnt;
    logic            row_term;
    logic            slice_term;
    logic            mat_term;
    logic            in_init;
    logic            in_mat_end;
    logic            last_mat;
    logic            slice_complete;
    logic            hold_xfer;
    logic            mat_inc;

    assign in_init    = (state == S_INIT);
    assign in_mat_end = (state == S_MAT_END);

    // mat_term can only be reached on the final matrix of a full-size job,
    // so it also guards against the index ever running past MAXMAT-1.
    assign last_mat       = (NW'(mat_idx) == (num_mat_q - NW'(1))) || mat_term;
    assign slice_complete = (EXT_DONE != 0) ? done : row_term;
    assign hold_xfer      = (state == S_HOLD) && out_ack && !abort;
    assign mat_inc        = hold_xfer && !last_mat;

    assign ready    = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign mat_done = (state == S_HOLD);
    assign job_done = hold_xfer && last_mat;

    // Rows processed within the current slice.
    cp_param_counter #(.WIDTH(RW), .TERM(ROWS)) u_row_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (in_init || in_mat_end),
        .load     (1'b0),
        .load_val ('0),
        .inc      (state == S_NEXT),
        .count    (row_cnt),
        .at_term  (row_term)
    );

    // Slice index, wrapped back to zero after the last slice.
    cp_param_counter #(.WIDTH(SW), .TERM(SLICES - 1)) u_slice_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (in_init),
        .load     (in_mat_end && slice_term),
        .load_val ('0),
        .inc      (in_mat_end),
        .count    (slice_idx),
        .at_term  (slice_term)
    );

    // Matrix index within the job.
    cp_param_counter #(.WIDTH(MW), .TERM(MAXMAT - 1)) u_mat_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (in_init),
        .load     (1'b0),
        .load_val ('0),
        .inc      (mat_inc),
        .count    (mat_idx),
        .at_term  (mat_term)
    );

    // Latch the job size when a start is accepted; a request for zero
    // matrices is run as a single matrix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_mat_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            num_mat_q <= (num_mat == '0) ? NW'(1) : num_mat;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and Moore strobes; abort overrides any busy state.
    always_comb begin
        next_state = state;
        ld1        = 1'b0;
        ld2        = 1'b0;
        ld3        = 1'b0;
        shift      = 1'b0;
        id_rst     = 1'b0;
        inc_i      = 1'b0;
        case (state)
            S_IDLE:      if (start) next_state = S_PREP;
            S_PREP:      next_state = S_LOAD_INIT;
            S_LOAD_INIT: begin ld1 = 1'b1; next_state = S_PAR1; end
            S_PAR1:      begin ld2 = 1'b1; next_state = S_PAR2; end
            S_PAR2:      begin ld3 = 1'b1; next_state = S_INIT; end
            S_INIT:      begin id_rst = 1'b1; next_state = S_LOAD; end
            S_LOAD:      begin ld1 = 1'b1; next_state = S_CALC; end
            S_CALC:      begin ld2 = 1'b1; next_state = S_PROC; end
            S_PROC:      begin shift = 1'b1; next_state = S_NEXT; end
            S_NEXT:      begin ld3 = 1'b1; inc_i = 1'b1; next_state = S_STAB; end
            S_STAB:      next_state = slice_complete ? S_MAT_END : S_PROC;
            S_MAT_END:   begin ld3 = 1'b1; id_rst = 1'b1; next_state = S_HOLD; end
            S_HOLD:      if (out_ack) next_state = last_mat ? S_IDLE : S_LOAD;
            default:     next_state = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end
    end

endmodule

// File: tb/tb_col_parity_sequencer.sv
// Self-checking bench for col_parity_sequencer: a vector table of whole jobs
// plus hand-written corner sequences, with a queue of expected matrix
// hand-offs compared at every transfer.
module tb_col_parity_sequencer;

    localparam int NW = 7;
    localparam int SW = 6;
    localparam int MW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          start_x = 1'b0;
    logic          done_d = 1'b0;
    logic          done_x = 1'b0;
    logic          abort = 1'b0;
    logic          out_ack = 1'b0;
    logic [NW-1:0] num_mat = '0;

    logic ready, busy, mat_done, job_done, ld1, ld2, ld3, shift, id_rst, inc_i;
    logic [SW-1:0] slice_idx;
    logic [MW-1:0] mat_idx;
    logic ready_x, busy_x, mat_done_x, job_done_x, ld1_x, ld2_x, ld3_x, shift_x, id_rst_x, inc_i_x;
    logic [SW-1:0] slice_idx_x;
    logic [MW-1:0] mat_idx_x;

    typedef struct {
        int mat_idx;
        int last;
    } exp_t;

    typedef struct {
        int num_mat;
        int ack_delay;
        bit busy_start;
        int e_mats;
        int e_ld1;
        int e_ld2;
        int e_ld3;
        int e_shift;
        int e_idrst;
        int e_md;
        int e_lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;

    col_parity_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_mat(num_mat),
        .done(done_d), .abort(abort), .out_ack(out_ack),
        .ready(ready), .busy(busy), .mat_done(mat_done), .job_done(job_done),
        .ld1(ld1), .ld2(ld2), .ld3(ld3), .shift(shift), .id_rst(id_rst), .inc_i(inc_i),
        .slice_idx(slice_idx), .mat_idx(mat_idx)
    );

    col_parity_sequencer #(.EXT_DONE(1)) dut_x (
        .clk(clk), .reset_n(reset_n), .start(start_x), .num_mat(num_mat),
        .done(done_x), .abort(abort), .out_ack(out_ack),
        .ready(ready_x), .busy(busy_x), .mat_done(mat_done_x), .job_done(job_done_x),
        .ld1(ld1_x), .ld2(ld2_x), .ld3(ld3_x), .shift(shift_x), .id_rst(id_rst_x), .inc_i(inc_i_x),
        .slice_idx(slice_idx_x), .mat_idx(mat_idx_x)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted matrix hand-off must match the next queued entry.
    always @(negedge clk) begin
        if (reset_n && mat_done && out_ack && !abort) begin
            if (sb_q.size() == 0) begin
                check_output("sb_unexpected_transfer", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("sb_mat_idx", int'(mat_idx), mon_e.mat_idx);
                check_output("sb_job_done", int'(job_done), mon_e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        start_x = 1'b0;
        abort   = 1'b0;
        out_ack = 1'b0;
        done_x  = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic push_job(input int mats);
        exp_t e;
        for (int m = 0; m < mats; m++) begin
            e.mat_idx = m;
            e.last    = (m == mats - 1) ? 1 : 0;
            sb_q.push_back(e);
        end
    endtask

    // Run one whole job from the vector table and compare event counts.
    task automatic apply_stimulus(input vec_t v);
        int c_ld1 = 0, c_ld2 = 0, c_ld3 = 0, c_shift = 0, c_inc = 0;
        int c_idrst = 0, c_md = 0, c_jd = 0, noisy = 0, hold = 0, lat = -1;
        do_reset();
        push_job(v.e_mats);
        num_mat = NW'(v.num_mat);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 1; k <= 400 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (v.busy_start) begin
                start   = (k == 3);
                num_mat = NW'(3);
            end
            if (mat_done) begin
                out_ack = (hold >= v.ack_delay);
                hold++;
            end else begin
                out_ack = 1'b0;
                hold    = 0;
            end
            #1;
            c_ld1   += int'(ld1);
            c_ld2   += int'(ld2);
            c_ld3   += int'(ld3);
            c_shift += int'(shift);
            c_inc   += int'(inc_i);
            c_idrst += int'(id_rst);
            if (mat_done) c_md++;
            if (mat_done && (ld1 | ld2 | ld3 | shift | id_rst | inc_i)) noisy++;
            if (job_done) begin
                c_jd++;
                lat = k;
            end
        end
        tick();
        out_ack = 1'b0;
        start   = 1'b0;
        check_output("vec_latency", lat, v.e_lat);
        check_output("vec_ld1", c_ld1, v.e_ld1);
        check_output("vec_ld2", c_ld2, v.e_ld2);
        check_output("vec_ld3", c_ld3, v.e_ld3);
        check_output("vec_shift", c_shift, v.e_shift);
        check_output("vec_inc_i", c_inc, v.e_shift);
        check_output("vec_id_rst", c_idrst, v.e_idrst);
        check_output("vec_mat_done_cycles", c_md, v.e_md);
        check_output("vec_job_done_count", c_jd, 1);
        check_output("vec_hold_strobes", noisy, 0);
        check_output("vec_sb_drained", sb_q.size(), 0);
        check_output("vec_back_idle", int'(ready), 1);
    endtask

    initial begin
        int found;
        int seen;
        int lat;
        int n_inc;
        int arm;

        // Outputs while reset is held from time zero.
        #3;
        check_output("por_ready", int'(ready), 1);
        check_output("por_busy", int'(busy), 0);
        check_output("por_mat_done", int'(mat_done), 0);
        check_output("por_job_done", int'(job_done), 0);
        check_output("por_strobes", int'(ld1 | ld2 | ld3 | shift | id_rst | inc_i), 0);
        check_output("por_idx", int'(slice_idx) + int'(mat_idx), 0);

        //          nm dly bs mats ld1 ld2 ld3 shf idr md  lat
        vecs[0] = '{2, 0, 1'b0, 2, 3, 3, 13, 10, 3, 2, 42};
        vecs[1] = '{0, 0, 1'b0, 1, 2, 2,  7,  5, 2, 1, 23};
        vecs[2] = '{1, 0, 1'b0, 1, 2, 2,  7,  5, 2, 1, 23};
        vecs[3] = '{3, 2, 1'b0, 3, 4, 4, 19, 15, 4, 9, 67};
        vecs[4] = '{1, 7, 1'b0, 1, 2, 2,  7,  5, 2, 8, 30};
        vecs[5] = '{1, 0, 1'b1, 1, 2, 2,  7,  5, 2, 1, 23};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Asynchronous reset in the PROC phase of the second matrix.
        do_reset();
        push_job(1);
        sb_q[0].last = 0;
        num_mat = NW'(2);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        found   = 0;
        seen    = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(posedge clk);
            #1;
            out_ack = mat_done;
            #1;
            if (mat_done && out_ack) seen = 1;
            if (seen == 1 && !mat_done && shift) found = 1;
        end
        check_output("rst_reached_proc", found, 1);
        check_output("rst_pre_slice_idx", int'(slice_idx), 1);
        check_output("rst_pre_mat_idx", int'(mat_idx), 1);
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_ready", int'(ready), 1);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_slice_idx", int'(slice_idx), 0);
        check_output("rst_mat_idx", int'(mat_idx), 0);
        out_ack = 1'b0;

        // Abort during CALC, then a fresh job must run normally.
        do_reset();
        num_mat = NW'(1);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        found   = 0;
        seen    = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            tick();
            if (id_rst) seen = 1;
            if (seen == 1 && ld2) found = 1;
        end
        check_output("abort_reached_calc", found, 1);
        abort = 1'b1;
        #1;
        check_output("abort_calc_no_job_done", int'(job_done), 0);
        tick();
        abort = 1'b0;
        #1;
        check_output("abort_ready", int'(ready), 1);
        check_output("abort_strobes", int'(ld1 | ld2 | ld3 | shift | id_rst | inc_i | job_done), 0);
        push_job(1);
        out_ack = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        lat     = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #2;
            if (job_done) lat = k;
        end
        check_output("abort_restart_latency", lat, 23);
        tick();
        out_ack = 1'b0;
        check_output("abort_restart_sb", sb_q.size(), 0);

        // Abort and acknowledge together in HOLD of the last matrix.
        do_reset();
        num_mat = NW'(1);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        found   = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            tick();
            if (mat_done) found = 1;
        end
        check_output("hold_abort_reached", found, 1);
        abort   = 1'b1;
        out_ack = 1'b1;
        #1;
        check_output("hold_abort_job_done", int'(job_done), 0);
        tick();
        abort   = 1'b0;
        out_ack = 1'b0;
        #1;
        check_output("hold_abort_ready", int'(ready), 1);
        check_output("hold_abort_mat_done", int'(mat_done), 0);

        // External done: slice ends on done in the third STAB.
        do_reset();
        num_mat = NW'(1);
        start_x = 1'b1;
        tick();
        start_x = 1'b0;
        found   = 0;
        n_inc   = 0;
        arm     = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick();
            done_x = (arm == 1);
            arm    = 0;
            if (inc_i_x) begin
                n_inc++;
                if (n_inc == 3) arm = 1;
            end
            if (ld3_x && id_rst_x) found = 1;
        end
        done_x = 1'b0;
        check_output("ext_mat_end_seen", found, 1);
        check_output("ext_inc_i_pulses", n_inc, 3);
        tick();
        check_output("ext_hold", int'(mat_done_x), 1);
        check_output("ext_slice_idx", int'(slice_idx_x), 1);
        out_ack = 1'b1;
        #1;
        check_output("ext_job_done", int'(job_done_x), 1);
        tick();
        out_ack = 1'b0;
        check_output("ext_back_idle", int'(ready_x), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/col_parity_sequencer.md
COL_PARITY_SEQUENCER -- requirements
Module: col_parity_sequencer

Interface
REQ-001 Parameter SLICES, default 64: slices per state matrix, 2..256.
REQ-002 Parameter ROWS, default 5: processing iterations per slice, used when EXT_DONE=0.
REQ-003 Parameter EXT_DONE, default 0: 1 ends a slice on the done input; 0 ends it on the internal row count.
REQ-004 Parameter MAXMAT, default 64: maximum matrices per job.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  job request, sampled only in IDLE.
REQ-008 num_mat  input  clog2(MAXMAT+1)  matrices in the job, latched on accepted start; 0 is treated as 1.
REQ-009 done  input  1  external slice-complete flag, used only when EXT_DONE=1.
REQ-010 abort  input  1  synchronous job cancel.
REQ-011 out_ack  input  1  downstream accepts the matrix-complete pulse.
REQ-012 ready  output  1  high in IDLE.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mat_done  output  1  matrix complete, held until acknowledged.
REQ-015 job_done  output  1  one-cycle pulse after the last matrix is acknowledged.
REQ-016 ld1, ld2, ld3, shift, id_rst, inc_i  output  1 each  datapath strobes.
REQ-017 slice_idx  output  clog2(SLICES)  current slice.
REQ-018 mat_idx  output  clog2(MAXMAT)  current matrix.

Function
REQ-019 FSM states: IDLE, PREP, LOAD_INIT, PAR1, PAR2, INIT, LOAD, CALC, PROC, NEXT, STAB, MAT_END, HOLD.
REQ-020 Transitions:
- IDLE -> PREP on start.
- PREP -> LOAD_INIT -> PAR1 -> PAR2 -> INIT -> LOAD -> CALC -> PROC -> NEXT -> STAB, unconditionally.
- STAB -> MAT_END if the slice is complete, else -> PROC.
- MAT_END -> HOLD.
REQ-021 HOLD behaviour:
- out_ack=1 and last matrix -> IDLE, with job_done pulsed in that same cycle.
- out_ack=1 and not last matrix -> LOAD.
- out_ack=0 -> stay in HOLD.
REQ-022 Strobes are Moore outputs, one state each, all other strobes 0:
- LOAD_INIT: ld1. PAR1: ld2. PAR2: ld3.
- INIT: id_rst, and slice_idx and mat_idx cleared to 0.
- LOAD: ld1. CALC: ld2. PROC: shift. NEXT: ld3 and inc_i.
- MAT_END: ld3 and id_rst.
REQ-023 Slice completion:
- EXT_DONE=1: complete when done=1 in STAB.
- EXT_DONE=0: an internal row counter increments on each NEXT and clears in INIT and MAT_END; complete when it reaches ROWS in STAB.
REQ-024 slice_idx increments in MAT_END and wraps from SLICES-1 to 0.
REQ-025 mat_idx increments when HOLD exits with out_ack=1 and is not the last matrix; the last matrix is mat_idx == latched num_mat-1.
REQ-026 mat_done is high throughout HOLD; mat_done=1 with out_ack=1 is a transfer.
REQ-027 abort in any non-IDLE state forces IDLE on the next edge, with no job_done and all strobes 0; abort in IDLE is ignored.
REQ-028 start while busy is ignored.
REQ-029 Simultaneous abort and out_ack in HOLD: abort wins.
REQ-030 Minimum latency, EXT_DONE=0, ROWS=1, num_mat=1: start accepted at edge 0, job_done high in the cycle after edge 11 when out_ack is held high.

Reset
REQ-031 reset_n low sets IDLE, clears all counters and the latched num_mat, and drives every output to 0 except ready=1, independent of clk.
REQ-032 Reset assertion mid-job discards the job; after deassertion the first action is the next accepted start.

Structure
REQ-033 A shared package cp_pkg holds the state encoding (4-bit enum) and the default parameter constants.
REQ-034 The single sub-module cp_param_counter (parametrised width, inc, clear, load, terminal flag) is used for the row, matrix and slice counters.

Verification
REQ-035 Reset: reset_n=0 mid-PROC -> ready=1, busy=0, slice_idx=0, mat_idx=0 immediately.
REQ-036 Defaults, num_mat=2, out_ack=1 -> ld1, ld2 and ld3 each once, then 5 PROC/NEXT loops per matrix; mat_done twice; job_done once; mat_idx 0->1.
REQ-037 Backpressure: out_ack=0 for 7 cycles in HOLD -> mat_done held 7 cycles, strobes 0, then LOAD.
REQ-038 EXT_DONE=1: done asserted in the 3rd STAB -> exactly 3 inc_i pulses before MAT_END.
REQ-039 abort in CALC -> IDLE next cycle, no job_done, and a subsequent start is accepted.
REQ-040 num_mat=0 -> treated as 1: one mat_done, then job_done.
